// File: rtl/z_result_stage_pkg.sv
// Shared definitions for the Z result stage: the ALU opcode map (kept in one
// place so the ALU and this stage agree) and a latency-counter sizing helper.
package z_result_stage_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHRA = 5'b00110;
  localparam logic [4:0] OP_SHL  = 5'b00111;
  localparam logic [4:0] OP_ROR  = 5'b01000;
  localparam logic [4:0] OP_ROL  = 5'b01001;
  localparam logic [4:0] OP_AND  = 5'b01010;
  localparam logic [4:0] OP_OR   = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_MUL  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;

  // Counter must hold LAT-1 for the longer latency; never narrower than 1 bit.
  function automatic int cnt_width(input int lat_a, input int lat_b);
    int m;
    m = (lat_a > lat_b) ? lat_a : lat_b;
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/z_result_stage_if.sv
// Signal bundle between the control/ALU side (master) and the Z result stage (slave).
interface z_result_stage_if #(
  parameter int OP_W = 5
);

  logic            start;
  logic [OP_W-1:0] op;
  logic [31:0]     alu_hi;
  logic [31:0]     alu_lo;
  logic            zhi_out_en;
  logic            zlo_out_en;

  logic [31:0]     z_hi;
  logic [31:0]     z_lo;
  logic [OP_W-1:0] z_op;
  logic            busy;
  logic            done;
  logic            overrun;
  logic [31:0]     bus_out;
  logic            bus_drive;

  modport master (
    output start, op, alu_hi, alu_lo, zhi_out_en, zlo_out_en,
    input  z_hi, z_lo, z_op, busy, done, overrun, bus_out, bus_drive
  );

  modport slave (
    input  start, op, alu_hi, alu_lo, zhi_out_en, zlo_out_en,
    output z_hi, z_lo, z_op, busy, done, overrun, bus_out, bus_drive
  );

endinterface

// File: rtl/z_lat_counter.sv
// Loadable down-counter with a zero flag; holds at zero rather than wrapping.
module z_lat_counter #(
  parameter int W = 6
) (
  input  logic         clock,
  input  logic         clear,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/z_result_stage.sv
// Z register pair capture stage behind the ALU: single-cycle ops capture on the
// launch edge, MUL/DIV capture a fixed number of edges later.
module z_result_stage
  import z_result_stage_pkg::*;
#(
  parameter int OP_W    = 5,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 33
) (
  input  logic           clock,
  input  logic           clear,
  z_result_stage_if.slave zif
);

  localparam int CNT_W = cnt_width(MUL_LAT, DIV_LAT);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t          state;
  state_t          next_state;
  logic [OP_W-1:0] op_q;
  logic [31:0]     z_hi_q;
  logic [31:0]     z_lo_q;
  logic [OP_W-1:0] z_op_q;
  logic            done_q;
  logic            overrun_q;

  logic            is_mul;
  logic            is_div;
  logic            load;
  logic            dec;
  logic [CNT_W-1:0] load_val;
  logic            cnt_zero;
  logic            capture;
  logic [OP_W-1:0] capture_op;

  assign is_mul = (zif.op == OP_W'(OP_MUL));
  assign is_div = (zif.op == OP_W'(OP_DIV));

  z_lat_counter #(
    .W(CNT_W)
  ) u_lat_counter (
    .clock    (clock),
    .clear    (clear),
    .load     (load),
    .dec      (dec),
    .load_val (load_val),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Counter is loaded with LAT-1 so the zero-flag edge is the LAT-th edge after launch.
  always_comb begin
    next_state = state;
    load       = 1'b0;
    dec        = 1'b0;
    load_val   = '0;
    capture    = 1'b0;
    capture_op = zif.op;
    unique case (state)
      IDLE: begin
        if (zif.start) begin
          if (is_mul || is_div) begin
            load       = 1'b1;
            load_val   = is_mul ? CNT_W'(MUL_LAT - 1) : CNT_W'(DIV_LAT - 1);
            next_state = WAIT;
          end else begin
            capture    = 1'b1;
            capture_op = zif.op;
          end
        end
      end
      WAIT: begin
        if (cnt_zero) begin
          capture    = 1'b1;
          capture_op = op_q;
          next_state = IDLE;
        end else begin
          dec = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      op_q      <= '0;
      z_hi_q    <= '0;
      z_lo_q    <= '0;
      z_op_q    <= '0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (load) begin
        op_q <= zif.op;
      end
      if (capture) begin
        z_hi_q <= zif.alu_hi;
        z_lo_q <= zif.alu_lo;
        z_op_q <= capture_op;
      end
      done_q <= capture;
      if (zif.start && (state == WAIT)) begin
        overrun_q <= 1'b1;
      end
    end
  end

  assign zif.z_hi    = z_hi_q;
  assign zif.z_lo    = z_lo_q;
  assign zif.z_op    = z_op_q;
  assign zif.busy    = (state == WAIT);
  assign zif.done    = done_q;
  assign zif.overrun = overrun_q;

  // High half has priority when both enables are asserted.
  assign zif.bus_out   = zif.zhi_out_en ? z_hi_q :
                         zif.zlo_out_en ? z_lo_q : 32'h0;
  assign zif.bus_drive = zif.zhi_out_en | zif.zlo_out_en;

endmodule

// File: tb/tb_z_result_stage.sv
// Self-checking bench for z_result_stage: vector table, hand-written latency
// sequences and a randomized run against an edge-indexed reference model.
module tb_z_result_stage;

  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 33;
  localparam logic [4:0] T_ADD = 5'b00011;
  localparam logic [4:0] T_MUL = 5'b10000;
  localparam logic [4:0] T_DIV = 5'b01111;

  logic clock;
  logic clear;

  z_result_stage_if #(.OP_W(5)) zif();

  z_result_stage #(
    .OP_W    (5),
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT)
  ) dut (
    .clock (clock),
    .clear (clear),
    .zif   (zif)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a multi-cycle op is remembered with the absolute edge number it completes on.
  int          edge_no = 0;
  bit          m_busy;
  int          m_cap_edge;
  logic [4:0]  m_op;
  logic [31:0] m_zhi;
  logic [31:0] m_zlo;
  logic [4:0]  m_zop;
  logic        m_done;
  logic        m_overrun;

  typedef struct {
    logic        start;
    logic [4:0]  op;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        zhi_en;
    logic        zlo_en;
    logic [31:0] e_zhi;
    logic [31:0] e_zlo;
    logic [4:0]  e_op;
    logic        e_done;
    logic [31:0] e_bus;
  } vec_t;

  vec_t vecs[8];

  task automatic model_reset();
    m_busy     = 0;
    m_cap_edge = 0;
    m_op       = '0;
    m_zhi      = '0;
    m_zlo      = '0;
    m_zop      = '0;
    m_done     = 1'b0;
    m_overrun  = 1'b0;
  endtask

  task automatic model_edge();
    m_done = 1'b0;
    if (m_busy) begin
      if (zif.start) m_overrun = 1'b1;
      if (edge_no == m_cap_edge) begin
        m_zhi  = zif.alu_hi;
        m_zlo  = zif.alu_lo;
        m_zop  = m_op;
        m_done = 1'b1;
        m_busy = 0;
      end
    end else if (zif.start) begin
      if (zif.op == T_MUL || zif.op == T_DIV) begin
        m_busy     = 1;
        m_op       = zif.op;
        m_cap_edge = edge_no + ((zif.op == T_MUL) ? MUL_LAT : DIV_LAT);
      end else begin
        m_zhi  = zif.alu_hi;
        m_zlo  = zif.alu_lo;
        m_zop  = zif.op;
        m_done = 1'b1;
      end
    end
    edge_no++;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic start, input logic [4:0] op,
                                input logic [31:0] hi, input logic [31:0] lo,
                                input logic zhi_en, input logic zlo_en);
    zif.start      = start;
    zif.op         = op;
    zif.alu_hi     = hi;
    zif.alu_lo     = lo;
    zif.zhi_out_en = zhi_en;
    zif.zlo_out_en = zlo_en;
  endtask

  task automatic check_output(input string tag);
    logic [31:0] e_bus;
    e_bus = zif.zhi_out_en ? m_zhi : (zif.zlo_out_en ? m_zlo : 32'h0);
    chk({tag, ".z_hi"},      zif.z_hi,      m_zhi);
    chk({tag, ".z_lo"},      zif.z_lo,      m_zlo);
    chk({tag, ".z_op"},      32'(zif.z_op), 32'(m_zop));
    chk({tag, ".busy"},      32'(zif.busy), 32'(m_busy));
    chk({tag, ".done"},      32'(zif.done), 32'(m_done));
    chk({tag, ".overrun"},   32'(zif.overrun), 32'(m_overrun));
    chk({tag, ".bus_out"},   zif.bus_out,   e_bus);
    chk({tag, ".bus_drive"}, 32'(zif.bus_drive), 32'(zif.zhi_out_en | zif.zlo_out_en));
  endtask

  initial begin
    vecs[0] = '{1'b1, T_ADD,    32'h0,         32'h7,         1'b0, 1'b0, 32'h0,         32'h7,         T_ADD,    1'b1, 32'h0};
    vecs[1] = '{1'b0, T_ADD,    32'hAAAA_AAAA, 32'h5555_5555, 1'b0, 1'b1, 32'h0,         32'h7,         T_ADD,    1'b0, 32'h7};
    vecs[2] = '{1'b1, 5'b00100, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0, 1'b1, 32'hDEAD_BEEF, 32'h1234_5678, 5'b00100, 1'b1, 32'h1234_5678};
    vecs[3] = '{1'b0, 5'b00000, 32'h1,         32'h2,         1'b1, 1'b1, 32'hDEAD_BEEF, 32'h1234_5678, 5'b00100, 1'b0, 32'hDEAD_BEEF};
    vecs[4] = '{1'b0, 5'b00000, 32'h1,         32'h2,         1'b1, 1'b0, 32'hDEAD_BEEF, 32'h1234_5678, 5'b00100, 1'b0, 32'hDEAD_BEEF};
    vecs[5] = '{1'b0, 5'b00000, 32'h1,         32'h2,         1'b0, 1'b0, 32'hDEAD_BEEF, 32'h1234_5678, 5'b00100, 1'b0, 32'h0};
    vecs[6] = '{1'b1, 5'b11111, 32'h0,         32'h0,         1'b0, 1'b0, 32'h0,         32'h0,         5'b11111, 1'b1, 32'h0};
    vecs[7] = '{1'b1, 5'b01010, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 1'b0, 1'b1, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 5'b01010, 1'b1, 32'h0F0F_0F0F};

    model_reset();
    clear = 1'b1;
    apply_stimulus(1'b0, 5'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    @(posedge clock);
    #1;
    chk("reset.z_hi", zif.z_hi, 32'h0);
    chk("reset.z_lo", zif.z_lo, 32'h0);
    chk("reset.busy", 32'(zif.busy), 32'h0);
    chk("reset.done", 32'(zif.done), 32'h0);
    chk("reset.overrun", 32'(zif.overrun), 32'h0);
    clear = 1'b0;

    // Vector table: single-cycle captures and bus selection.
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(vecs[i].start, vecs[i].op, vecs[i].hi, vecs[i].lo,
                     vecs[i].zhi_en, vecs[i].zlo_en);
      tick();
      chk($sformatf("vec%0d.z_hi", i), zif.z_hi, vecs[i].e_zhi);
      chk($sformatf("vec%0d.z_lo", i), zif.z_lo, vecs[i].e_zlo);
      chk($sformatf("vec%0d.z_op", i), 32'(zif.z_op), 32'(vecs[i].e_op));
      chk($sformatf("vec%0d.done", i), 32'(zif.done), 32'(vecs[i].e_done));
      chk($sformatf("vec%0d.busy", i), 32'(zif.busy), 32'h0);
      chk($sformatf("vec%0d.bus_out", i), zif.bus_out, vecs[i].e_bus);
      chk($sformatf("vec%0d.bus_drive", i), 32'(zif.bus_drive),
          32'(vecs[i].zhi_en | vecs[i].zlo_en));
    end

    // MUL with a stray start mid-flight, then a relaunch in the done cycle.
    apply_stimulus(1'b1, T_MUL, 32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0);
    tick();
    chk("mul.e0.busy", 32'(zif.busy), 32'h1);
    chk("mul.e0.z_hi", zif.z_hi, 32'hF0F0_F0F0);
    apply_stimulus(1'b0, T_ADD, 32'h3333_3333, 32'h4444_4444, 1'b0, 1'b0);
    tick();
    chk("mul.e1.busy", 32'(zif.busy), 32'h1);
    apply_stimulus(1'b1, T_ADD, 32'h5555_5555, 32'h6666_6666, 1'b0, 1'b1);
    tick();
    chk("mul.e2.overrun", 32'(zif.overrun), 32'h1);
    chk("mul.e2.stale_bus", zif.bus_out, 32'h0F0F_0F0F);
    apply_stimulus(1'b0, T_ADD, 32'h7777_7777, 32'h8888_8888, 1'b0, 1'b0);
    tick();
    chk("mul.e3.busy", 32'(zif.busy), 32'h1);
    chk("mul.e3.done", 32'(zif.done), 32'h0);
    apply_stimulus(1'b0, T_ADD, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 1'b0);
    tick();
    chk("mul.e4.z_hi", zif.z_hi, 32'h0000_0001);
    chk("mul.e4.z_lo", zif.z_lo, 32'hFFFF_FFFE);
    chk("mul.e4.z_op", 32'(zif.z_op), 32'(T_MUL));
    chk("mul.e4.done", 32'(zif.done), 32'h1);
    chk("mul.e4.busy", 32'(zif.busy), 32'h0);
    apply_stimulus(1'b1, T_MUL, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    chk("mul2.launch.busy", 32'(zif.busy), 32'h1);
    chk("mul2.launch.done", 32'(zif.done), 32'h0);
    apply_stimulus(1'b0, T_ADD, 32'hABCD_0000, 32'h0000_ABCD, 1'b0, 1'b0);
    for (int i = 0; i < MUL_LAT; i++) tick();
    chk("mul2.done", 32'(zif.done), 32'h1);
    chk("mul2.z_hi", zif.z_hi, 32'hABCD_0000);
    chk("mul2.overrun_sticky", 32'(zif.overrun), 32'h1);
    check_output("mul2");

    // Clear between edges during a DIV wait abandons the op.
    apply_stimulus(1'b1, T_DIV, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    apply_stimulus(1'b0, T_ADD, 32'h9999_9999, 32'h9999_9999, 1'b0, 1'b0);
    repeat (5) tick();
    chk("div_clr.busy_before", 32'(zif.busy), 32'h1);
    #3;
    clear = 1'b1;
    model_reset();
    #1;
    chk("div_clr.z_hi", zif.z_hi, 32'h0);
    chk("div_clr.z_lo", zif.z_lo, 32'h0);
    chk("div_clr.busy", 32'(zif.busy), 32'h0);
    chk("div_clr.done", 32'(zif.done), 32'h0);
    chk("div_clr.overrun", 32'(zif.overrun), 32'h0);
    #2;
    clear = 1'b0;
    for (int i = 0; i < DIV_LAT + 4; i++) begin
      tick();
      chk("div_clr.no_done", 32'(zif.done), 32'h0);
    end
    check_output("div_clr.after");
    apply_stimulus(1'b1, T_ADD, 32'h0, 32'h55, 1'b0, 1'b0);
    tick();
    chk("div_clr.add.z_lo", zif.z_lo, 32'h55);
    chk("div_clr.add.done", 32'(zif.done), 32'h1);

    // Full DIV latency: busy for DIV_LAT cycles, capture on edge DIV_LAT.
    apply_stimulus(1'b1, T_DIV, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    chk("div.e0.busy", 32'(zif.busy), 32'h1);
    for (int i = 1; i < DIV_LAT; i++) begin
      apply_stimulus(1'b0, T_ADD, $urandom, $urandom, 1'b0, 1'b0);
      tick();
      chk($sformatf("div.e%0d.busy", i), 32'(zif.busy), 32'h1);
      chk($sformatf("div.e%0d.done", i), 32'(zif.done), 32'h0);
    end
    apply_stimulus(1'b0, T_ADD, 32'hCAFE_F00D, 32'h0000_0021, 1'b0, 1'b0);
    tick();
    chk("div.cap.z_hi", zif.z_hi, 32'hCAFE_F00D);
    chk("div.cap.z_lo", zif.z_lo, 32'h0000_0021);
    chk("div.cap.z_op", 32'(zif.z_op), 32'(T_DIV));
    chk("div.cap.done", 32'(zif.done), 32'h1);
    chk("div.cap.busy", 32'(zif.busy), 32'h0);
    tick();
    chk("div.after.done", 32'(zif.done), 32'h0);

    // Randomized run against the reference model.
    for (int i = 0; i < 400; i++) begin
      logic [4:0] rop;
      int sel;
      sel = $urandom_range(0, 15);
      if (sel < 3)       rop = T_MUL;
      else if (sel == 3) rop = T_DIV;
      else               rop = 5'($urandom_range(0, 31));
      apply_stimulus(($urandom_range(0, 2) == 0), rop, $urandom, $urandom,
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      tick();
      check_output($sformatf("rand%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
